// File: rtl/arm_lp_pkg.sv
// Shared definitions for the ARM-LP datapath control: stage encoding and
// default handshake timeout.
package arm_lp_pkg;

    localparam int unsigned STAGE_WIDTH            = 3;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [STAGE_WIDTH-1:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } stageT;

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Handshake wait counter shared by the FETCH and MEMORY stages; flags expiry
// on the last allowed cycle when ready is still low.
module wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count,
    input  logic ready,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturates at LAST so an expired wait never wraps back into range.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count && !ready && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = count && !ready && (count_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle phase sequencer: steps each instruction through the datapath
// stages and drives the PC, cache, ALU and register-file control strobes.
module stage_sequencer
    import arm_lp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned COUNT_WIDTH    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   haltRequest,
    input  logic                   instrReady,
    input  logic                   dataReady,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic                   branch,
    input  logic                   unconditionalBranch,
    input  logic                   regWriteFlag,
    input  logic                   aluZero,
    output logic                   instrReq,
    output logic                   instrLatch,
    output logic                   aluEnable,
    output logic                   dataReq,
    output logic                   regWriteEnable,
    output logic                   pcWrite,
    output logic                   pcSrc,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic                   busError,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retiredCount
);

    stageT state_q;
    stageT state_d;

    logic memRead_q;
    logic memWrite_q;
    logic branch_q;
    logic uncondBranch_q;
    logic regWrite_q;
    logic busError_q;
    logic [COUNT_WIDTH-1:0] retired_q;

    logic timerClear;
    logic timerCount;
    logic timerReady;
    logic timerExpired;
    logic busErrorSet;

    // Kept outside the FSM block so the timer's expiry feeds next-state logic
    // without a combinational path back through the same process.
    assign timerCount = !reset && (((state_q == FETCH) && !haltRequest) || (state_q == MEMORY));
    assign timerReady = (state_q == FETCH) ? instrReady : dataReady;
    assign timerClear = (state_d != state_q);

    wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_waitTimer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timerClear),
        .count  (timerCount),
        .ready  (timerReady),
        .expired(timerExpired)
    );

    // Everything is forced low while reset is high, so an instruction caught
    // mid-flight never emits its pcWrite or register write.
    always_comb begin
        state_d        = state_q;
        instrReq       = 1'b0;
        instrLatch     = 1'b0;
        aluEnable      = 1'b0;
        dataReq        = 1'b0;
        regWriteEnable = 1'b0;
        pcWrite        = 1'b0;
        pcSrc          = 1'b0;
        halted         = 1'b0;
        busErrorSet    = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    if (haltRequest) begin
                        state_d = HALT;
                    end else begin
                        instrReq = 1'b1;
                        if (instrReady) begin
                            instrLatch = 1'b1;
                            state_d    = DECODE;
                        end else if (timerExpired) begin
                            busErrorSet = 1'b1;
                            state_d     = HALT;
                        end
                    end
                end
                DECODE: begin
                    state_d = EXECUTE;
                end
                EXECUTE: begin
                    aluEnable = 1'b1;
                    if (memRead_q || memWrite_q) begin
                        state_d = MEMORY;
                    end else if (branch_q || uncondBranch_q) begin
                        pcWrite = 1'b1;
                        pcSrc   = uncondBranch_q || (branch_q && aluZero);
                        state_d = FETCH;
                    end else if (regWrite_q) begin
                        state_d = WRITEBACK;
                    end else begin
                        pcWrite = 1'b1;
                        state_d = FETCH;
                    end
                end
                MEMORY: begin
                    dataReq = 1'b1;
                    if (dataReady) begin
                        if (memRead_q) begin
                            state_d = WRITEBACK;
                        end else begin
                            pcWrite = 1'b1;
                            state_d = FETCH;
                        end
                    end else if (timerExpired) begin
                        busErrorSet = 1'b1;
                        state_d     = HALT;
                    end
                end
                WRITEBACK: begin
                    regWriteEnable = 1'b1;
                    pcWrite        = 1'b1;
                    state_d        = FETCH;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Decode flags are captured once, on DECODE exit, with load-over-store and
    // unconditional-over-conditional priority already applied.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= FETCH;
            memRead_q      <= 1'b0;
            memWrite_q     <= 1'b0;
            branch_q       <= 1'b0;
            uncondBranch_q <= 1'b0;
            regWrite_q     <= 1'b0;
            busError_q     <= 1'b0;
            retired_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                memRead_q      <= memRead;
                memWrite_q     <= memWrite && !memRead;
                branch_q       <= branch && !unconditionalBranch;
                uncondBranch_q <= unconditionalBranch;
                regWrite_q     <= regWriteFlag;
            end
            if (busErrorSet) begin
                busError_q <= 1'b1;
            end
            if (pcWrite) begin
                retired_q <= retired_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign stage        = reset ? '0 : state_q;
    assign busError     = busError_q && !reset;
    assign retiredCount = reset ? '0 : retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer: instruction classes,
// handshake timeout boundary, halt and reset behaviour.
module tb_stage_sequencer;

    logic        clock;
    logic        reset;
    logic        haltRequest;
    logic        instrReady;
    logic        dataReady;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic        unconditionalBranch;
    logic        regWriteFlag;
    logic        aluZero;
    logic        instrReq;
    logic        instrLatch;
    logic        aluEnable;
    logic        dataReq;
    logic        regWriteEnable;
    logic        pcWrite;
    logic        pcSrc;
    logic [2:0]  stage;
    logic        busError;
    logic        halted;
    logic [31:0] retiredCount;

    int checks = 0;
    int errors = 0;

    stage_sequencer #(
        .TIMEOUT_CYCLES(16),
        .COUNT_WIDTH   (32)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .haltRequest        (haltRequest),
        .instrReady         (instrReady),
        .dataReady          (dataReady),
        .memRead            (memRead),
        .memWrite           (memWrite),
        .branch             (branch),
        .unconditionalBranch(unconditionalBranch),
        .regWriteFlag       (regWriteFlag),
        .aluZero            (aluZero),
        .instrReq           (instrReq),
        .instrLatch         (instrLatch),
        .aluEnable          (aluEnable),
        .dataReq            (dataReq),
        .regWriteEnable     (regWriteEnable),
        .pcWrite            (pcWrite),
        .pcSrc              (pcSrc),
        .stage              (stage),
        .busError           (busError),
        .halted             (halted),
        .retiredCount       (retiredCount)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives every input at once, then lets combinational outputs settle.
    task automatic applyStimulus(input logic h, input logic iR, input logic dR,
                                 input logic mR, input logic mW, input logic br,
                                 input logic ub, input logic rw, input logic z);
        haltRequest         = h;
        instrReady          = iR;
        dataReady           = dR;
        memRead             = mR;
        memWrite            = mW;
        branch              = br;
        unconditionalBranch = ub;
        regWriteFlag        = rw;
        aluZero             = z;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // From FETCH: latch an instruction with the given flags, leave in EXECUTE.
    task automatic runFetchDecode(input logic mR, input logic mW, input logic br,
                                  input logic ub, input logic rw);
        applyStimulus(0, 1, 0, mR, mW, br, ub, rw, 0);
        checkOutput("fetchStage", 32'(stage), 32'd0);
        checkOutput("fetchLatch", 32'(instrLatch), 32'd1);
        tick();
        applyStimulus(0, 0, 0, mR, mW, br, ub, rw, 0);
        checkOutput("decodeStage", 32'(stage), 32'd1);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resetStage", 32'(stage), 32'd0);
        checkOutput("resetRetired", retiredCount, 32'd0);
        checkOutput("resetBusError", 32'(busError), 32'd0);
        checkOutput("resetPcWrite", 32'(pcWrite), 32'd0);
        checkOutput("fetchReqIdle", 32'(instrReq), 32'd1);

        // ADD-like: F D E W F
        runFetchDecode(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("addExecStage", 32'(stage), 32'd2);
        checkOutput("addAluEnable", 32'(aluEnable), 32'd1);
        checkOutput("addExecPcWrite", 32'(pcWrite), 32'd0);
        tick();
        checkOutput("addWbStage", 32'(stage), 32'd4);
        checkOutput("addRegWrite", 32'(regWriteEnable), 32'd1);
        checkOutput("addPcWrite", 32'(pcWrite), 32'd1);
        checkOutput("addPcSrc", 32'(pcSrc), 32'd0);
        checkOutput("addRetiredBefore", retiredCount, 32'd0);
        tick();
        checkOutput("addEndStage", 32'(stage), 32'd0);
        checkOutput("addRetiredAfter", retiredCount, 32'd1);

        // Load with three wait cycles before dataReady.
        runFetchDecode(1, 0, 0, 0, 1);
        checkOutput("loadExecStage", 32'(stage), 32'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("loadWaitStage", 32'(stage), 32'd3);
            checkOutput("loadWaitReq", 32'(dataReq), 32'd1);
            checkOutput("loadWaitPcWrite", 32'(pcWrite), 32'd0);
            tick();
        end
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 1, 0);
        checkOutput("loadReadyReq", 32'(dataReq), 32'd1);
        checkOutput("loadReadyPcWrite", 32'(pcWrite), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("loadWbStage", 32'(stage), 32'd4);
        checkOutput("loadWbPcWrite", 32'(pcWrite), 32'd1);
        tick();
        checkOutput("loadEndReq", 32'(dataReq), 32'd0);
        checkOutput("loadRetired", retiredCount, 32'd2);

        // CBZ taken, CBZ not taken, then B with aluZero low.
        runFetchDecode(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
        checkOutput("cbzTakenPcWrite", 32'(pcWrite), 32'd1);
        checkOutput("cbzTakenPcSrc", 32'(pcSrc), 32'd1);
        tick();
        checkOutput("cbzTakenStage", 32'(stage), 32'd0);
        checkOutput("cbzTakenRetired", retiredCount, 32'd3);
        runFetchDecode(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("cbzNotPcWrite", 32'(pcWrite), 32'd1);
        checkOutput("cbzNotPcSrc", 32'(pcSrc), 32'd0);
        tick();
        checkOutput("cbzNotStage", 32'(stage), 32'd0);
        runFetchDecode(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("bPcSrc", 32'(pcSrc), 32'd1);
        tick();
        checkOutput("bRetired", retiredCount, 32'd5);

        // memRead and memWrite together behave as a load.
        runFetchDecode(1, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("conflictMemPcWrite", 32'(pcWrite), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("conflictWbStage", 32'(stage), 32'd4);
        tick();
        checkOutput("conflictRetired", retiredCount, 32'd6);

        // Store with ready on the last allowed cycle: completes normally.
        runFetchDecode(0, 1, 0, 0, 0);
        tick();
        for (int i = 1; i < 16; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("lateStoreStage", 32'(stage), 32'd3);
            tick();
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("lateStoreStage16", 32'(stage), 32'd3);
        checkOutput("lateStorePcWrite", 32'(pcWrite), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lateStoreEndStage", 32'(stage), 32'd0);
        checkOutput("lateStoreBusError", 32'(busError), 32'd0);
        checkOutput("lateStoreRetired", retiredCount, 32'd7);

        // Store never acknowledged: fault after 16 MEMORY cycles.
        runFetchDecode(0, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            checkOutput("timeoutStage", 32'(stage), 32'd3);
            checkOutput("timeoutPcWrite", 32'(pcWrite), 32'd0);
            tick();
        end
        checkOutput("timeoutHaltStage", 32'(stage), 32'd5);
        checkOutput("timeoutBusError", 32'(busError), 32'd1);
        checkOutput("timeoutHalted", 32'(halted), 32'd1);
        checkOutput("timeoutRetired", retiredCount, 32'd7);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("haltAbsorbStage", 32'(stage), 32'd5);
        checkOutput("haltNoInstrReq", 32'(instrReq), 32'd0);
        checkOutput("haltNoDataReq", 32'(dataReq), 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstStage", 32'(stage), 32'd0);
        checkOutput("rstRetired", retiredCount, 32'd0);
        checkOutput("rstBusError", 32'(busError), 32'd0);
        checkOutput("rstHalted", 32'(halted), 32'd0);

        // haltRequest beats instrReady in FETCH.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("haltReqLatch", 32'(instrLatch), 32'd0);
        checkOutput("haltReqInstrReq", 32'(instrReq), 32'd0);
        tick();
        checkOutput("haltReqStage", 32'(stage), 32'd5);
        checkOutput("haltReqHalted", 32'(halted), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("haltRstStage", 32'(stage), 32'd0);

        // Reset in MEMORY with dataReady high abandons the store.
        runFetchDecode(0, 1, 0, 0, 0);
        tick();
        reset = 1'b1;
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("memRstPcWrite", 32'(pcWrite), 32'd0);
        tick();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("memRstStage", 32'(stage), 32'd0);
        checkOutput("memRstRetired", retiredCount, 32'd0);

        // ALU-only op without register write retires from EXECUTE.
        runFetchDecode(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("nopPcWrite", 32'(pcWrite), 32'd1);
        checkOutput("nopPcSrc", 32'(pcSrc), 32'd0);
        tick();
        checkOutput("nopStage", 32'(stage), 32'd0);
        checkOutput("nopRetired", retiredCount, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
